reg_xfer_seq: RTL

- Micro-sequencer for the register-transfer and index-increment/decrement instruction group of the 6502 core.
- Accepts one decoded opcode per handshake and drives the load/bus-enable strobes of X, Y, ACC, S, AI and BI, plus the ALU control lines, over a fixed multi-cycle schedule.
- Sits between the instruction decoder and the register file / ALU input registers.
- Ownership rule: this block is the only driver of those strobes while BUSY=1.

---
 rtl/reg_xfer_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/reg_xfer_seq.sv
// Micro-sequencer for the 6502 register-transfer and INX/INY/DEX/DEY group.
// Drives register-file, SB/DB and ALU strobes from registered state only.
module reg_xfer_seq #(
  parameter int unsigned STEP_HOLD    = 0,
  parameter bit          ILLEGAL_FLAG = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [7:0] op_code,
  output logic       op_ready,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       x_load,
  output logic       y_load,
  output logic       acc_load,
  output logic       x_sb_en,
  output logic       y_sb_en,
  output logic       acc_sb_en,
  output logic       s_sb_en,
  output logic       s_sb_load,
  output logic       ai_sb_load,
  output logic       bi_db_load,
  output logic       bi_inv_db_load,
  output logic       db_zero,
  output logic       alu_sum,
  output logic       alu_cin,
  output logic       alu_to_sb,
  output logic       nz_load
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_ALU_LD,
    S_ALU_EX,
    S_ALU_WB,
    S_BAD
  } state_t;

  typedef enum logic [1:0] {
    C_XFER,
    C_INCDEC,
    C_BAD
  } op_class_t;

  typedef enum logic [1:0] {
    R_X,
    R_Y,
    R_A,
    R_S
  } reg_sel_t;

  localparam logic [2:0] HOLD_LAST = 3'(STEP_HOLD);

  state_t     state;
  state_t     state_next;
  logic [2:0] hold_cnt;
  logic [7:0] op_q;
  logic       last_cycle;
  logic       accept;

  reg_sel_t   src;
  reg_sel_t   dst;
  logic       is_inc;

  function automatic op_class_t classify(input logic [7:0] op);
    case (op)
      8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hBA, 8'h9A: classify = C_XFER;
      8'hE8, 8'hC8, 8'hCA, 8'h88:               classify = C_INCDEC;
      default:                                  classify = C_BAD;
    endcase
  endfunction

  assign accept     = (state == S_IDLE) && op_valid;
  assign last_cycle = (hold_cnt == HOLD_LAST);

  // State register, hold counter and latched opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values; blocking here would create ordering races.
      state    <= S_IDLE;
      hold_cnt <= 3'd0;
      // NOTE: the opcode latch is a single register, so it is cleared on reset
      // like any other control state; only wide storage arrays are left unreset.
      op_q     <= 8'h00;
    end else begin
      state <= state_next;
      if (state != S_IDLE && !last_cycle) begin
        hold_cnt <= hold_cnt + 3'd1;
      end else begin
        hold_cnt <= 3'd0;
      end
      if (accept) begin
        op_q <= op_code;
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (op_valid) begin
          unique case (classify(op_code))
            C_XFER:   state_next = S_XFER;
            C_INCDEC: state_next = S_ALU_LD;
            default:  state_next = S_BAD;
          endcase
        end
      end
      S_XFER:   if (last_cycle) state_next = S_IDLE;
      S_ALU_LD: if (last_cycle) state_next = S_ALU_EX;
      S_ALU_EX: if (last_cycle) state_next = S_ALU_WB;
      S_ALU_WB: if (last_cycle) state_next = S_IDLE;
      S_BAD:    if (last_cycle) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Source/destination decode of the latched opcode.
  always_comb begin
    src    = R_X;
    dst    = R_X;
    is_inc = 1'b0;
    case (op_q)
      8'hAA: begin src = R_A; dst = R_X; end
      8'hA8: begin src = R_A; dst = R_Y; end
      8'h8A: begin src = R_X; dst = R_A; end
      8'h98: begin src = R_Y; dst = R_A; end
      8'hBA: begin src = R_S; dst = R_X; end
      8'h9A: begin src = R_X; dst = R_S; end
      8'hE8: begin src = R_X; dst = R_X; is_inc = 1'b1; end
      8'hC8: begin src = R_Y; dst = R_Y; is_inc = 1'b1; end
      8'hCA: begin src = R_X; dst = R_X; end
      8'h88: begin src = R_Y; dst = R_Y; end
      default: ;
    endcase
  end

  // Output decode: depends only on state, hold counter and latched opcode.
  always_comb begin
    logic src_act;
    logic dst_act;

    src_act        = 1'b0;
    dst_act        = 1'b0;
    done           = 1'b0;
    illegal        = 1'b0;
    ai_sb_load     = 1'b0;
    bi_db_load     = 1'b0;
    bi_inv_db_load = 1'b0;
    db_zero        = 1'b0;
    alu_sum        = 1'b0;
    alu_cin        = 1'b0;
    alu_to_sb      = 1'b0;
    nz_load        = 1'b0;

    unique case (state)
      S_XFER: begin
        src_act = 1'b1;
        dst_act = 1'b1;
        nz_load = (dst != R_S);
        done    = last_cycle;
      end
      S_ALU_LD: begin
        src_act        = 1'b1;
        ai_sb_load     = 1'b1;
        db_zero        = 1'b1;
        bi_db_load     = is_inc;
        bi_inv_db_load = !is_inc;
      end
      S_ALU_EX: begin
        alu_sum = 1'b1;
        alu_cin = is_inc;
      end
      S_ALU_WB: begin
        alu_to_sb = 1'b1;
        alu_sum   = 1'b1;
        alu_cin   = is_inc;
        dst_act   = 1'b1;
        nz_load   = 1'b1;
        done      = last_cycle;
      end
      S_BAD: begin
        illegal = ILLEGAL_FLAG && last_cycle;
        done    = last_cycle;
      end
      default: ;
    endcase

    x_sb_en   = src_act && (src == R_X);
    y_sb_en   = src_act && (src == R_Y);
    acc_sb_en = src_act && (src == R_A);
    s_sb_en   = src_act && (src == R_S);
    x_load    = dst_act && (dst == R_X);
    y_load    = dst_act && (dst == R_Y);
    acc_load  = dst_act && (dst == R_A);
    s_sb_load = dst_act && (dst == R_S);
  end

  assign op_ready = (state == S_IDLE);
  assign busy     = !op_ready;

endmodule
